// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns a command/response handshake into one
// AXI-Lite read or write, with a per-transaction timeout so a dead slave cannot hang it.
module axi_lite_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        FCLK_CLK0,
  input  logic        RST,
  // Command channel
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_write,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_wdata,
  input  logic [3:0]  i_cmd_wstrb,
  // Response channel
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic [1:0]  o_rsp_resp,
  output logic        o_rsp_timeout,
  // AXI-Lite master
  output logic [31:0] AXI_awaddr,
  output logic [2:0]  AXI_awprot,
  output logic        AXI_awvalid,
  input  logic        AXI_awready,
  output logic [31:0] AXI_wdata,
  output logic [3:0]  AXI_wstrb,
  output logic        AXI_wvalid,
  input  logic        AXI_wready,
  input  logic [1:0]  AXI_bresp,
  input  logic        AXI_bvalid,
  output logic        AXI_bready,
  output logic [31:0] AXI_araddr,
  output logic [2:0]  AXI_arprot,
  output logic        AXI_arvalid,
  input  logic        AXI_arready,
  input  logic [31:0] AXI_rdata,
  input  logic [1:0]  AXI_rresp,
  input  logic        AXI_rvalid,
  output logic        AXI_rready
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StWrAwW, StWrB, StRdAr, StRdR, StRsp} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            aw_done, w_done, active, finishing;

  assign AXI_awprot = 3'b000;
  assign AXI_arprot = 3'b000;

  // A channel counts as done if already handshaken earlier or handshaking this cycle.
  assign aw_done = !AXI_awvalid || AXI_awready;
  assign w_done  = !AXI_wvalid || AXI_wready;
  assign active  = (state_q == StWrAwW) || (state_q == StWrB) ||
                   (state_q == StRdAr) || (state_q == StRdR);
  assign finishing = ((state_q == StWrAwW) && aw_done && w_done && AXI_bvalid) ||
                     ((state_q == StWrB) && AXI_bvalid) ||
                     ((state_q == StRdR) && AXI_rvalid);

  always_ff @(posedge FCLK_CLK0 or posedge RST) begin
    if (RST) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      o_cmd_ready   <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_resp    <= '0;
      o_rsp_timeout <= 1'b0;
      AXI_awaddr    <= '0;
      AXI_awvalid   <= 1'b0;
      AXI_wdata     <= '0;
      AXI_wstrb     <= '0;
      AXI_wvalid    <= 1'b0;
      AXI_bready    <= 1'b0;
      AXI_araddr    <= '0;
      AXI_arvalid   <= 1'b0;
      AXI_rready    <= 1'b0;
    end else begin
      if (active) cnt_q <= cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          o_cmd_ready <= 1'b1;
          if (i_cmd_valid && o_cmd_ready) begin
            o_cmd_ready   <= 1'b0;
            cnt_q         <= '0;
            o_rsp_rdata   <= '0;
            o_rsp_resp    <= '0;
            o_rsp_timeout <= 1'b0;
            if (i_cmd_write) begin
              AXI_awaddr  <= i_cmd_addr;
              AXI_wdata   <= i_cmd_wdata;
              AXI_wstrb   <= i_cmd_wstrb;
              AXI_awvalid <= 1'b1;
              AXI_wvalid  <= 1'b1;
              AXI_bready  <= 1'b1;
              state_q     <= StWrAwW;
            end else begin
              AXI_araddr  <= i_cmd_addr;
              AXI_arvalid <= 1'b1;
              state_q     <= StRdAr;
            end
          end
        end
        StWrAwW: begin
          if (AXI_awready) AXI_awvalid <= 1'b0;
          if (AXI_wready) AXI_wvalid <= 1'b0;
          if (aw_done && w_done) begin
            if (AXI_bvalid) begin
              AXI_bready  <= 1'b0;
              o_rsp_resp  <= AXI_bresp;
              o_rsp_valid <= 1'b1;
              state_q     <= StRsp;
            end else begin
              state_q <= StWrB;
            end
          end
        end
        StWrB: begin
          if (AXI_bvalid) begin
            AXI_bready  <= 1'b0;
            o_rsp_resp  <= AXI_bresp;
            o_rsp_valid <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRdAr: begin
          if (AXI_arready) begin
            AXI_arvalid <= 1'b0;
            AXI_rready  <= 1'b1;
            state_q     <= StRdR;
          end
        end
        StRdR: begin
          if (AXI_rvalid) begin
            AXI_rready  <= 1'b0;
            o_rsp_rdata <= AXI_rdata;
            o_rsp_resp  <= AXI_rresp;
            o_rsp_valid <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRsp: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      // Timeout abort overrides any partial progress; a completing transfer wins instead.
      if (active && !finishing && (cnt_q == CntLast)) begin
        AXI_awvalid   <= 1'b0;
        AXI_wvalid    <= 1'b0;
        AXI_bready    <= 1'b0;
        AXI_arvalid   <= 1'b0;
        AXI_rready    <= 1'b0;
        o_rsp_rdata   <= '0;
        o_rsp_resp    <= 2'b11;
        o_rsp_timeout <= 1'b1;
        o_rsp_valid   <= 1'b1;
        state_q       <= StRsp;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: bench drives the slave side by hand, cycle by cycle.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [31:0] i_cmd_addr, i_cmd_wdata;
  logic [3:0]  i_cmd_wstrb;
  logic        o_rsp_valid, i_rsp_ready, o_rsp_timeout;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int errors = 0;
  int checks = 0;
  int aw_hs = 0;
  int w_hs = 0;
  int n, aw0, w0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (awvalid && awready) aw_hs <= aw_hs + 1;
    if (wvalid && wready) w_hs <= w_hs + 1;
  end

  axi_lite_master #(.TIMEOUT_CYCLES(16)) dut (
    .FCLK_CLK0(clk), .RST(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
    .AXI_awaddr(awaddr), .AXI_awprot(awprot), .AXI_awvalid(awvalid), .AXI_awready(awready),
    .AXI_wdata(wdata), .AXI_wstrb(wstrb), .AXI_wvalid(wvalid), .AXI_wready(wready),
    .AXI_bresp(bresp), .AXI_bvalid(bvalid), .AXI_bready(bready),
    .AXI_araddr(araddr), .AXI_arprot(arprot), .AXI_arvalid(arvalid), .AXI_arready(arready),
    .AXI_rdata(rdata), .AXI_rresp(rresp), .AXI_rvalid(rvalid), .AXI_rready(rready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    check("cmd_ready_before", 32'(o_cmd_ready), 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = addr;
    i_cmd_wdata = data;
    i_cmd_wstrb = strb;
    step;
    i_cmd_valid = 1'b0;
    check("cmd_ready_busy", 32'(o_cmd_ready), 32'd0);
  endtask

  task automatic finish_rsp;
    i_rsp_ready = 1'b1;
    step;
    i_rsp_ready = 1'b0;
    check("rsp_released", 32'(o_rsp_valid), 32'd0);
    check("cmd_ready_again", 32'(o_cmd_ready), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                         input int hold);
    send_cmd(1'b0, addr, 32'd0, 4'd0);
    check("ar_valid", 32'(arvalid), 32'd1);
    check("ar_addr", araddr, addr);
    arready = 1'b1;
    step;
    arready = 1'b0;
    check("ar_dropped", 32'(arvalid), 32'd0);
    check("r_ready_at_rvalid", 32'(rready), 32'd1);
    check("rsp_not_early", 32'(o_rsp_valid), 32'd0);
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    step;
    rvalid = 1'b0;
    rdata  = 32'd0;
    rresp  = 2'd0;
    check("rd_rsp_valid", 32'(o_rsp_valid), 32'd1);
    check("rd_rsp_rdata", o_rsp_rdata, data);
    check("rd_rsp_resp", 32'(o_rsp_resp), 32'(resp));
    check("rd_rsp_timeout", 32'(o_rsp_timeout), 32'd0);
    check("r_ready_dropped", 32'(rready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      step;
      check("hold_valid", 32'(o_rsp_valid), 32'd1);
      check("hold_rdata", o_rsp_rdata, data);
      check("hold_cmd_ready", 32'(o_cmd_ready), 32'd0);
    end
    finish_rsp;
  endtask

  initial begin
    i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = 0; i_cmd_wdata = 0; i_cmd_wstrb = 0;
    i_rsp_ready = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;

    // Reset state
    step; step;
    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_awprot", 32'(awprot), 32'd0);
    rst = 1'b0;
    step;
    check("post_rst_cmd_ready", 32'(o_cmd_ready), 32'd1);

    // Zero-wait write with B alongside AW/W
    aw0 = aw_hs; w0 = w_hs;
    send_cmd(1'b1, 32'h0, 32'hA5A5_0001, 4'hF);
    check("w0_awvalid", 32'(awvalid), 32'd1);
    check("w0_wvalid", 32'(wvalid), 32'd1);
    check("w0_awaddr", awaddr, 32'h0);
    check("w0_wdata", wdata, 32'hA5A5_0001);
    check("w0_wstrb", 32'(wstrb), 32'hF);
    check("w0_bready", 32'(bready), 32'd1);
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
    step;
    awready = 0; wready = 0; bvalid = 0;
    check("w0_aw_dropped", 32'(awvalid), 32'd0);
    check("w0_w_dropped", 32'(wvalid), 32'd0);
    check("w0_no_wr_b", 32'(bready), 32'd0);
    check("w0_rsp_valid", 32'(o_rsp_valid), 32'd1);
    check("w0_rsp_resp", 32'(o_rsp_resp), 32'd0);
    check("w0_rsp_timeout", 32'(o_rsp_timeout), 32'd0);
    check("w0_rsp_rdata", o_rsp_rdata, 32'd0);
    check("w0_aw_hs", 32'(aw_hs - aw0), 32'd1);
    finish_rsp;

    // Write with awready three cycles late, wready immediate
    aw0 = aw_hs; w0 = w_hs;
    send_cmd(1'b1, 32'h8, 32'h1234_5678, 4'h3);
    wready = 1;
    step;
    wready = 0;
    check("sk_wvalid_dropped", 32'(wvalid), 32'd0);
    check("sk_awvalid_held", 32'(awvalid), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step;
      check("sk_awvalid_wait", 32'(awvalid), 32'd1);
    end
    awready = 1;
    step;
    awready = 0;
    check("sk_awvalid_dropped", 32'(awvalid), 32'd0);
    check("sk_wr_b_bready", 32'(bready), 32'd1);
    check("sk_no_rsp_yet", 32'(o_rsp_valid), 32'd0);
    bvalid = 1; bresp = 2'b01;
    step;
    bvalid = 0; bresp = 2'b00;
    check("sk_rsp_valid", 32'(o_rsp_valid), 32'd1);
    check("sk_rsp_resp", 32'(o_rsp_resp), 32'd1);
    check("sk_bready_dropped", 32'(bready), 32'd0);
    check("sk_aw_hs", 32'(aw_hs - aw0), 32'd1);
    check("sk_w_hs", 32'(w_hs - w0), 32'd1);
    finish_rsp;

    // Reads: mapped register and unmapped address with SLVERR
    do_read(32'h4, 32'h0000_00C3, 2'b00, 0);
    do_read(32'h100, 32'hDEAD_BEEF, 2'b10, 0);

    // Timeout: arready never asserted
    send_cmd(1'b0, 32'h20, 32'd0, 4'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!arvalid) break;
      n++;
      step;
    end
    check("to_ar_cycles", 32'(n), 32'd16);
    check("to_rsp_valid", 32'(o_rsp_valid), 32'd1);
    check("to_rsp_timeout", 32'(o_rsp_timeout), 32'd1);
    check("to_rsp_resp", 32'(o_rsp_resp), 32'd3);
    check("to_rsp_rdata", o_rsp_rdata, 32'd0);
    check("to_rready", 32'(rready), 32'd0);
    finish_rsp;
    do_read(32'h24, 32'h1357_9BDF, 2'b00, 0);

    // Reset while waiting in WR_B
    send_cmd(1'b1, 32'h30, 32'h0000_CAFE, 4'hF);
    awready = 1; wready = 1;
    step;
    awready = 0; wready = 0;
    check("rb_in_wr_b", 32'(bready), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rb_bready_cleared", 32'(bready), 32'd0);
    check("rb_cmd_ready_cleared", 32'(o_cmd_ready), 32'd0);
    check("rb_awaddr_cleared", awaddr, 32'd0);
    step;
    rst = 1'b0;
    bvalid = 1; bresp = 2'b00;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step;
      if (o_rsp_valid) n++;
    end
    bvalid = 0;
    check("rb_no_response", 32'(n), 32'd0);
    check("rb_cmd_ready", 32'(o_cmd_ready), 32'd1);

    // Response backpressure for five cycles
    do_read(32'hC, 32'h0000_55AA, 2'b00, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
